// File: rtl/conv_filter5_mac.sv
`default_nettype none
// ============================================================================
// conv_filter5_mac : serial signed MAC over one FHxFWxFC window plus bias,
//                    with a registered result saturated to 2*BITWIDTH bits.
// Revision 1.0 - initial release
// ============================================================================
module conv_filter5_mac #(
  parameter int BITWIDTH       = 8,
  parameter int FILTER_HEIGHT  = 5,
  parameter int FILTER_WIDTH   = 5,
  parameter int FILTER_CHANNEL = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [BITWIDTH-1:0]   weight,
  input  logic signed [BITWIDTH-1:0]   data,
  input  logic signed [2*BITWIDTH-1:0] bias,
  output logic signed [2*BITWIDTH-1:0] result
);

  localparam int N     = FILTER_HEIGHT * FILTER_WIDTH * FILTER_CHANNEL;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * BITWIDTH;
  localparam int ACC_W = PW + CNT_W;
  localparam int SUM_W = ACC_W + 1;

  localparam logic [CNT_W-1:0]        C_LAST    = CNT_W'(N - 1);
  localparam logic signed [SUM_W-1:0] C_SAT_MAX = SUM_W'((2 ** (PW - 1)) - 1);
  localparam logic signed [SUM_W-1:0] C_SAT_MIN = SUM_W'(-(2 ** (PW - 1)));

  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic signed [ACC_W-1:0] acc_q,    acc_d;
  logic signed [PW-1:0]    result_q, result_d;

  logic signed [PW-1:0]    prod_w;
  logic signed [ACC_W-1:0] prod_ext_w;
  logic signed [SUM_W-1:0] sum_w;

  assign prod_w     = weight * data;
  assign prod_ext_w = {{(ACC_W - PW){prod_w[PW-1]}}, prod_w};

  // Final sum is one bit wider than the accumulator so the bias can never wrap it.
  assign sum_w = {acc_q[ACC_W-1], acc_q}
               + {prod_ext_w[ACC_W-1], prod_ext_w}
               + {{(SUM_W - PW){bias[PW-1]}}, bias};

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (cnt_q == C_LAST) begin
      cnt_d = '0;
      acc_d = '0;
      if (sum_w > C_SAT_MAX) begin
        result_d = C_SAT_MAX[PW-1:0];
      end else if (sum_w < C_SAT_MIN) begin
        result_d = C_SAT_MIN[PW-1:0];
      end else begin
        result_d = sum_w[PW-1:0];
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      acc_d = acc_q + prod_ext_w;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_filter5_mac.sv
`default_nettype none
// ============================================================================
// tb_conv_filter5_mac : directed and randomized windows against a queue-based
//                       window-sum reference model.
// Revision 1.0 - initial release
// ============================================================================
module tb_conv_filter5_mac;

  localparam int BW = 8;
  localparam int N  = 75;

  logic                   clk;
  logic                   reset;
  logic signed [BW-1:0]   weight;
  logic signed [BW-1:0]   data;
  logic signed [2*BW-1:0] bias;
  logic signed [2*BW-1:0] result;

  int n_checks;
  int n_pass;
  int prods_q[$];
  int res_m;

  conv_filter5_mac #(
    .BITWIDTH      (BW),
    .FILTER_HEIGHT (5),
    .FILTER_WIDTH  (5),
    .FILTER_CHANNEL(3)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .weight(weight),
    .data  (data),
    .bias  (bias),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp16(input int s);
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  // Drive one element, clock it, then compare against the window-sum model.
  task automatic step(input int w, input int d, input int b, input string tag);
    int s;
    weight = BW'(w);
    data   = BW'(d);
    bias   = (2*BW)'(b);
    @(posedge clk);
    #1;
    prods_q.push_back(w * d);
    if (prods_q.size() == N) begin
      s = b;
      foreach (prods_q[i]) s += prods_q[i];
      res_m = clamp16(s);
      prods_q.delete();
    end
    check(tag, int'(result), res_m);
  endtask

  task automatic window(input int w, input int d, input int b_other, input int b_last,
                        input string tag);
    for (int i = 0; i < N; i++) begin
      step(w, d, (i == N - 1) ? b_last : b_other, tag);
    end
  endtask

  initial begin
    int w, d, b, nel;
    n_checks = 0;
    n_pass   = 0;
    res_m    = 0;
    reset    = 1'b0;
    weight   = '0;
    data     = '0;
    bias     = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_result", int'(result), 0);
    reset = 1'b1;

    window(1, 1, 0, 0, "ones");
    check("ones_final", int'(result), 75);

    window(2, -3, 10, 10, "neg_bias");
    check("neg_bias_final", int'(result), -440);

    window(127, 127, 0, 0, "sat_pos");
    check("sat_pos_final", int'(result), 32767);

    window(-128, 127, 0, 0, "sat_neg");
    check("sat_neg_final", int'(result), -32768);

    window(1, 1, 0, 0, "b2b_w1");
    check("b2b_w1_final", int'(result), 75);
    window(0, 0, -5, -5, "b2b_w2");
    check("b2b_w2_final", int'(result), -5);

    window(1, 1, 1000, 7, "bias_sample");
    check("bias_sample_final", int'(result), 82);

    for (int i = 0; i < 40; i++) step(1, 1, 0, "pre_abort");
    reset = 1'b0;
    #1;
    check("async_reset", int'(result), 0);
    prods_q.delete();
    res_m = 0;
    @(posedge clk);
    #1;
    check("reset_hold", int'(result), 0);
    reset = 1'b1;
    window(1, 1, 0, 0, "post_abort");
    check("post_abort_final", int'(result), 75);

    // Random windows with bias varying every cycle and occasional aborts.
    for (int k = 0; k < 20; k++) begin
      nel = (k % 7 == 3) ? int'($urandom_range(1, N - 1)) : N;
      for (int i = 0; i < nel; i++) begin
        w = int'($urandom_range(0, 255)) - 128;
        d = int'($urandom_range(0, 255)) - 128;
        b = int'($urandom_range(0, 65535)) - 32768;
        step(w, d, b, "rand");
      end
      if (nel != N) begin
        reset = 1'b0;
        #1;
        prods_q.delete();
        res_m = 0;
        check("rand_abort", int'(result), 0);
        #2;
        reset = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
